// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one SPI master among NUM_REQ descriptor requesters.
// Optional WAIT watchdog compiled in with `define SPI_ARB_TIMEOUT_EN.
module spi_master_arbiter #(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned LEN_WIDTH      = 6,
   parameter int unsigned GAP_CYCLES     = 2,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_REQ-1:0]              req_valid_i,
   output logic [NUM_REQ-1:0]              req_ready_o,
   input  logic [NUM_REQ*2-1:0]            req_cs_i,
   input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data_i,
   output logic [NUM_REQ-1:0]              rsp_valid_o,
   output logic [DATA_WIDTH-1:0]           rsp_data_o,
   output logic                            rsp_err_o,
   output logic [NUM_REQ-1:0]              grant_o,
   output logic                            spi_start_o,
   output logic [1:0]                      spi_cs_o,
   output logic [LEN_WIDTH-1:0]            spi_len_o,
   output logic [DATA_WIDTH-1:0]           spi_data_o,
   input  logic                            spi_done_i,
   input  logic [DATA_WIDTH-1:0]           spi_rx_i
);

   localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [LEN_WIDTH-1:0] LEN_MAX = LEN_WIDTH'(DATA_WIDTH);
   localparam logic [IW-1:0] OWNER_LAST = IW'(NUM_REQ - 1);
   localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

   typedef enum logic [2:0] {IDLE, START, WAIT, RESP, GAP} state_t;

   state_t                  state_q, state_d;
   logic [IW-1:0]           ptr_q, owner_q, winner, scan_idx;
   logic                    any_valid;
   logic [1:0]              cs_sel;
   logic [LEN_WIDTH-1:0]    len_sel;
   logic [DATA_WIDTH-1:0]   data_sel;
   logic [GW-1:0]           gap_cnt_q;
   logic [NUM_REQ-1:0]      grant_q;
   logic                    timeout_evt;

   // First valid requester at or above the pointer, wrapping round.
   always_comb begin
      any_valid = 1'b0;
      winner    = '0;
      scan_idx  = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         scan_idx = IW'((32'(ptr_q) + i) % NUM_REQ);
         if (!any_valid && req_valid_i[scan_idx]) begin
            any_valid = 1'b1;
            winner    = scan_idx;
         end
      end
   end

   always_comb begin
      cs_sel   = req_cs_i[32'(winner)*2 +: 2];
      len_sel  = req_len_i[32'(winner)*LEN_WIDTH +: LEN_WIDTH];
      data_sel = req_data_i[32'(winner)*DATA_WIDTH +: DATA_WIDTH];
   end

`ifdef SPI_ARB_TIMEOUT_EN
   localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] wait_cnt_q;
   logic          rsp_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt_q <= '0;
         rsp_err_q  <= 1'b0;
      end else begin
         wait_cnt_q <= (state_q == WAIT) ? wait_cnt_q + 1'b1 : '0;
         if (state_q == IDLE && any_valid && len_sel == '0)
            rsp_err_q <= 1'b0;
         else if (state_q == WAIT && spi_done_i)
            rsp_err_q <= 1'b0;
         else if (timeout_evt)
            rsp_err_q <= 1'b1;
      end
   end

   // A done arriving on the last watchdog cycle still wins over the timeout.
   always_comb timeout_evt = (state_q == WAIT) && !spi_done_i && (wait_cnt_q == TO_LAST);
   always_comb rsp_err_o   = rsp_err_q;
`else
   logic unused_timeout;

   // Parameter kept so instantiations stay identical with the watchdog compiled out.
   always_comb unused_timeout = ^TIMEOUT_CYCLES;
   always_comb timeout_evt    = 1'b0;
   always_comb rsp_err_o      = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_valid) state_d = (len_sel == '0) ? RESP : START;
         START:   state_d = WAIT;
         WAIT:    if (spi_done_i || timeout_evt) state_d = RESP;
         RESP:    state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
         GAP:     if (gap_cnt_q == GAP_LAST) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Accept strobe is masked while reset is held so nothing is acknowledged then.
   always_comb begin
      req_ready_o = '0;
      if (state_q == IDLE && any_valid && rst_n)
         req_ready_o[winner] = 1'b1;
      spi_start_o = (state_q == START);
      rsp_valid_o = (state_q == RESP) ? grant_q : '0;
      grant_o     = grant_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q      <= '0;
         owner_q    <= '0;
         grant_q    <= '0;
         spi_cs_o   <= '0;
         spi_len_o  <= '0;
         spi_data_o <= '0;
         rsp_data_o <= '0;
         gap_cnt_q  <= '0;
      end else begin
         gap_cnt_q <= (state_q == GAP) ? gap_cnt_q + 1'b1 : '0;
         case (state_q)
            IDLE: begin
               if (any_valid) begin
                  owner_q    <= winner;
                  grant_q    <= ONE_HOT0 << winner;
                  spi_cs_o   <= cs_sel;
                  spi_len_o  <= (len_sel > LEN_MAX) ? LEN_MAX : len_sel;
                  spi_data_o <= data_sel;
                  if (len_sel == '0) rsp_data_o <= '0;
               end
            end
            WAIT: begin
               if (spi_done_i)       rsp_data_o <= spi_rx_i;
               else if (timeout_evt) rsp_data_o <= '0;
            end
            RESP: begin
               ptr_q   <= (owner_q == OWNER_LAST) ? '0 : owner_q + 1'b1;
               grant_q <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed self-checking bench for spi_master_arbiter (4 requesters, GAP 2, timeout 16).
module tb_spi_master_arbiter;

   localparam int NR = 4;
   localparam int DW = 32;
   localparam int LW = 6;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NR-1:0]     req_valid = '0;
   logic [NR*2-1:0]   req_cs = '0;
   logic [NR*LW-1:0]  req_len = '0;
   logic [NR*DW-1:0]  req_data = '0;
   logic [NR-1:0]     req_ready, rsp_valid, grant;
   logic [DW-1:0]     rsp_data;
   logic              rsp_err;
   logic              spi_start;
   logic [1:0]        spi_cs;
   logic [LW-1:0]     spi_len;
   logic [DW-1:0]     spi_data;
   logic              spi_done = 1'b0;
   logic [DW-1:0]     spi_rx = '0;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   spi_master_arbiter #(
      .NUM_REQ(NR), .DATA_WIDTH(DW), .LEN_WIDTH(LW),
      .GAP_CYCLES(2), .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_cs_i(req_cs), .req_len_i(req_len), .req_data_i(req_data),
      .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
      .grant_o(grant), .spi_start_o(spi_start), .spi_cs_o(spi_cs),
      .spi_len_o(spi_len), .spi_data_o(spi_data),
      .spi_done_i(spi_done), .spi_rx_i(spi_rx)
   );

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic set_desc(input int r, input logic [1:0] cs, input logic [LW-1:0] len,
                           input logic [DW-1:0] data);
      req_cs[r*2 +: 2]     = cs;
      req_len[r*LW +: LW]  = len;
      req_data[r*DW +: DW] = data;
   endtask

   task automatic apply_reset;
      rst_n = 1'b0; req_valid = '0; spi_done = 1'b0; spi_rx = '0;
      tick; tick;
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #3;
      n_cmp++; if (grant !== 4'b0) begin n_err++; $display("FAIL reset_grant: got %b want 0000", grant); end
      n_cmp++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
      n_cmp++; if (rsp_valid !== 4'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid); end
      n_cmp++; if (spi_start !== 1'b0) begin n_err++; $display("FAIL reset_start: got %b want 0", spi_start); end
      n_cmp++; if ({spi_cs, spi_len, spi_data} !== '0) begin n_err++; $display("FAIL reset_spi_desc: got %h/%h/%h want 0", spi_cs, spi_len, spi_data); end
      n_cmp++; if ({rsp_err, rsp_data} !== '0) begin n_err++; $display("FAIL reset_rsp: got %b/%h want 0", rsp_err, rsp_data); end
      tick; tick;
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_single;
      set_desc(0, 2'd2, 6'd8, 32'hA5);
      req_valid = 4'b0001;
      #1;
      n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single_ready: got %b want 0001", req_ready); end
      tick; req_valid = '0; #1;
      n_cmp++; if (spi_start !== 1'b1) begin n_err++; $display("FAIL single_start: got %b want 1", spi_start); end
      n_cmp++; if ({spi_cs, spi_len, spi_data} !== {2'd2, 6'd8, 32'hA5}) begin n_err++; $display("FAIL single_desc: got %h/%h/%h want 2/08/a5", spi_cs, spi_len, spi_data); end
      n_cmp++; if (grant !== 4'b0001) begin n_err++; $display("FAIL single_grant: got %b want 0001", grant); end
      tick;
      n_cmp++; if (spi_start !== 1'b0) begin n_err++; $display("FAIL single_start_width: got %b want 0", spi_start); end
      tick; spi_done = 1'b1; spi_rx = 32'h3C;
      tick; spi_done = 1'b0; spi_rx = '0; #1;
      n_cmp++; if (rsp_valid !== 4'b0001) begin n_err++; $display("FAIL single_rsp_valid: got %b want 0001", rsp_valid); end
      n_cmp++; if (rsp_data !== 32'h3C) begin n_err++; $display("FAIL single_rsp_data: got %h want 3c", rsp_data); end
      n_cmp++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL single_rsp_err: got %b want 0", rsp_err); end
      tick;
      n_cmp++; if ({rsp_valid, grant} !== 8'h00) begin n_err++; $display("FAIL single_after_resp: got %b/%b want 0/0", rsp_valid, grant); end
      n_cmp++; if (rsp_data !== 32'h3C) begin n_err++; $display("FAIL single_rsp_hold: got %h want 3c", rsp_data); end
      tick; tick;
   endtask

   task automatic test_round_robin;
      int n;
      logic [3:0] oh;
      apply_reset;
      for (int r = 0; r < NR; r++) set_desc(r, 2'(r), 6'(8 + r), 32'hC0DE_0000 + 32'(r));
      req_valid = 4'hF;
      #1;
      for (int t = 0; t < 5; t++) begin
         oh = 4'b0001 << (t % 4);
         n = 0;
         while (spi_start !== 1'b1 && n < 20) begin
            if (req_ready !== 4'b0) begin
               n_cmp++; if (req_ready !== oh) begin n_err++; $display("FAIL rr_ready[%0d]: got %b want %b", t, req_ready, oh); end
            end
            tick; n++;
         end
         n_cmp++; if (spi_start !== 1'b1) begin n_err++; $display("FAIL rr_start_timeout[%0d]: got %b want 1", t, spi_start); end
         n_cmp++; if (grant !== oh) begin n_err++; $display("FAIL rr_grant[%0d]: got %b want %b", t, grant, oh); end
         n_cmp++; if (spi_data !== 32'hC0DE_0000 + 32'(t % 4)) begin n_err++; $display("FAIL rr_data[%0d]: got %h want %h", t, spi_data, 32'hC0DE_0000 + 32'(t % 4)); end
         if (t > 0) begin
            n_cmp++; if (n !== 4) begin n_err++; $display("FAIL rr_gap[%0d]: got %0d cycles want 4", t, n); end
         end
         repeat (5) tick;
         spi_done = 1'b1; spi_rx = 32'h5000 + 32'(t);
         tick; spi_done = 1'b0; #1;
         n_cmp++; if (rsp_valid !== oh) begin n_err++; $display("FAIL rr_rsp_valid[%0d]: got %b want %b", t, rsp_valid, oh); end
         n_cmp++; if (rsp_data !== 32'h5000 + 32'(t)) begin n_err++; $display("FAIL rr_rsp_data[%0d]: got %h want %h", t, rsp_data, 32'h5000 + 32'(t)); end
         if (t == 4) req_valid = '0;
      end
      tick; tick; tick;
   endtask

   task automatic test_len_zero;
      set_desc(2, 2'd1, 6'd0, 32'hDEAD);
      req_valid = 4'b0100;
      #1;
      n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL len0_ready: got %b want 0100", req_ready); end
      tick; req_valid = '0; #1;
      n_cmp++; if (spi_start !== 1'b0) begin n_err++; $display("FAIL len0_no_start: got %b want 0", spi_start); end
      n_cmp++; if (rsp_valid !== 4'b0100) begin n_err++; $display("FAIL len0_rsp_valid: got %b want 0100", rsp_valid); end
      n_cmp++; if ({rsp_err, rsp_data} !== '0) begin n_err++; $display("FAIL len0_rsp: got %b/%h want 0/0", rsp_err, rsp_data); end
      tick; spi_done = 1'b1; spi_rx = '1;
      tick; spi_done = 1'b0; #1;
      n_cmp++; if (rsp_valid !== 4'b0) begin n_err++; $display("FAIL spurious_gap: got %b want 0000", rsp_valid); end
      tick; spi_done = 1'b1;
      tick; spi_done = 1'b0; #1;
      n_cmp++; if (rsp_valid !== 4'b0) begin n_err++; $display("FAIL spurious_idle: got %b want 0000", rsp_valid); end
      n_cmp++; if (rsp_data !== 32'h0) begin n_err++; $display("FAIL spurious_data: got %h want 0", rsp_data); end
      spi_rx = '0;
   endtask

   task automatic test_len_clamp;
      set_desc(3, 2'd3, 6'd40, 32'h1234_5678);
      req_valid = 4'b1000;
      #1;
      n_cmp++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL clamp_ready: got %b want 1000", req_ready); end
      tick; req_valid = '0; #1;
      n_cmp++; if ({spi_start, spi_cs, spi_len} !== {1'b1, 2'd3, 6'd32}) begin n_err++; $display("FAIL clamp_len: got %b/%h/%0d want 1/3/32", spi_start, spi_cs, spi_len); end
      tick; tick; spi_done = 1'b1; spi_rx = 32'h8765_4321;
      tick; spi_done = 1'b0; #1;
      n_cmp++; if ({rsp_valid, rsp_data} !== {4'b1000, 32'h8765_4321}) begin n_err++; $display("FAIL clamp_rsp: got %b/%h want 1000/87654321", rsp_valid, rsp_data); end
      tick; tick; tick;
   endtask

   task automatic test_descriptor_hold;
      set_desc(0, 2'd1, 6'd16, 32'h1111_2222);
      req_valid = 4'b0001;
      #1;
      tick; req_valid = '0;
      set_desc(0, 2'd3, 6'd5, 32'hFFFF_FFFF);
      #1;
      n_cmp++; if ({spi_cs, spi_len, spi_data} !== {2'd1, 6'd16, 32'h1111_2222}) begin n_err++; $display("FAIL hold_start: got %h/%h/%h want 1/10/11112222", spi_cs, spi_len, spi_data); end
      tick; tick;
      n_cmp++; if ({spi_cs, spi_len, spi_data} !== {2'd1, 6'd16, 32'h1111_2222}) begin n_err++; $display("FAIL hold_wait: got %h/%h/%h want 1/10/11112222", spi_cs, spi_len, spi_data); end
      spi_done = 1'b1; spi_rx = 32'hABCD;
      tick; spi_done = 1'b0; #1;
      n_cmp++; if (rsp_valid !== 4'b0001) begin n_err++; $display("FAIL hold_rsp: got %b want 0001", rsp_valid); end
      tick; tick; tick;
   endtask

   task automatic test_timeout;
      logic bad;
      set_desc(1, 2'd0, 6'd8, 32'h77);
      req_valid = 4'b0010;
      #1;
      tick; req_valid = '0; #1;
      n_cmp++; if (spi_start !== 1'b1) begin n_err++; $display("FAIL to_start: got %b want 1", spi_start); end
      bad = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      repeat (16) begin tick; if (rsp_valid !== 4'b0) bad = 1'b1; end
      n_cmp++; if (bad !== 1'b0) begin n_err++; $display("FAIL to_early: got early rsp_valid want none"); end
      tick;
      n_cmp++; if ({rsp_valid, rsp_err, rsp_data} !== {4'b0010, 1'b1, 32'h0}) begin n_err++; $display("FAIL to_rsp: got %b/%b/%h want 0010/1/0", rsp_valid, rsp_err, rsp_data); end
      tick; tick; tick;
      spi_done = 1'b1; spi_rx = 32'h99;
      tick; spi_done = 1'b0; #1;
      n_cmp++; if ({rsp_valid, rsp_err, rsp_data} !== {4'b0000, 1'b1, 32'h0}) begin n_err++; $display("FAIL to_late_done: got %b/%b/%h want 0000/1/0", rsp_valid, rsp_err, rsp_data); end
`else
      repeat (30) begin tick; if (rsp_valid !== 4'b0) bad = 1'b1; end
      n_cmp++; if (bad !== 1'b0) begin n_err++; $display("FAIL wait_forever: got rsp_valid want none"); end
      n_cmp++; if (grant !== 4'b0010) begin n_err++; $display("FAIL wait_grant: got %b want 0010", grant); end
      spi_done = 1'b1; spi_rx = 32'h99;
      tick; spi_done = 1'b0; #1;
      n_cmp++; if ({rsp_valid, rsp_err, rsp_data} !== {4'b0010, 1'b0, 32'h99}) begin n_err++; $display("FAIL wait_rsp: got %b/%b/%h want 0010/0/99", rsp_valid, rsp_err, rsp_data); end
      tick; tick; tick;
`endif
   endtask

   task automatic test_reset_mid_wait;
      set_desc(2, 2'd2, 6'd8, 32'h55);
      set_desc(3, 2'd1, 6'd12, 32'h3333);
      req_valid = 4'b1100;
      #1;
      n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL rst_pre_ready: got %b want 0100", req_ready); end
      tick; req_valid = 4'b1000;
      tick; tick; #1;
      rst_n = 1'b0;
      #1;
      n_cmp++; if ({grant, req_ready, rsp_valid, spi_start} !== 13'h0) begin n_err++; $display("FAIL rst_mid_ctrl: got %b/%b/%b/%b want 0", grant, req_ready, rsp_valid, spi_start); end
      n_cmp++; if ({spi_cs, spi_len, spi_data, rsp_err, rsp_data} !== '0) begin n_err++; $display("FAIL rst_mid_data: got %h/%h/%h/%b/%h want 0", spi_cs, spi_len, spi_data, rsp_err, rsp_data); end
      tick;
      rst_n = 1'b1;
      #1;
      n_cmp++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL rst_post_ready: got %b want 1000", req_ready); end
      tick; req_valid = '0; #1;
      n_cmp++; if ({grant, spi_start, spi_data} !== {4'b1000, 1'b1, 32'h3333}) begin n_err++; $display("FAIL rst_post_grant: got %b/%b/%h want 1000/1/3333", grant, spi_start, spi_data); end
      tick; spi_done = 1'b1; spi_rx = 32'h1;
      tick; spi_done = 1'b0; #1;
      n_cmp++; if (rsp_valid !== 4'b1000) begin n_err++; $display("FAIL rst_post_rsp: got %b want 1000", rsp_valid); end
      tick; tick; tick;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset;
      test_single;
      test_round_robin;
      test_len_zero;
      test_len_clamp;
      test_descriptor_hold;
      test_timeout;
      test_reset_mid_wait;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
